// File: rtl/csi2_vc_demux.sv
// CSI-2 RX virtual-channel demultiplexer: parses packet headers from the aligned
// D-PHY byte stream, routes payload bytes per VC with byte enables and drops the CRC.
module csi2_vc_demux #(
    parameter int         LANE_COUNT = 4,
    parameter logic [3:0] VC_EN      = 4'hF,
    localparam int        DW         = 8 * LANE_COUNT
) (
    input  logic                  clk_byte_fr_i,
    input  logic                  reset_byte_fr_n_i,
    input  logic [DW-1:0]         data_i,
    input  logic                  valid_i,
    input  logic                  sot_i,
    output logic                  sp_en_o,
    output logic                  lp_en_o,
    output logic [1:0]            vc_o,
    output logic [5:0]            dt_o,
    output logic [15:0]           wc_o,
    output logic [7:0]            ecc_o,
    output logic [DW-1:0]         pl_data_o,
    output logic [LANE_COUNT-1:0] pl_be_o,
    output logic                  pl_valid_o,
    output logic [3:0]            frame_active_o,
    output logic                  err_trunc_o,
    output logic                  err_fe_o
);

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t                state, next_state;
    logic [31:0]           hdr_buf, next_hdr_buf, hdr_word;
    logic [2:0]            hdr_cnt, next_hdr_cnt, hdr_cnt_new;
    logic [16:0]           rem, next_rem, take, pay;
    logic                  start, hdr_beat, body_beat, decode, is_short, pl_ok;
    logic [LANE_COUNT-1:0] be;

    // A sot beat always restarts header collection, whatever state we are in.
    assign start     = valid_i && sot_i;
    assign hdr_beat  = start || (valid_i && state == HDR);
    assign body_beat = valid_i && !sot_i && state == BODY;

    always_comb begin
        if (start) begin
            hdr_word    = 32'(data_i);
            hdr_cnt_new = 3'(LANE_COUNT);
        end else begin
            hdr_word    = hdr_buf | (32'(data_i) << {hdr_cnt, 3'b000});
            hdr_cnt_new = hdr_cnt + 3'(LANE_COUNT);
        end
    end

    assign decode   = hdr_beat && hdr_cnt_new == 3'd4;
    assign is_short = hdr_word[5:0] <= 6'h0F;

    // rem counts payload plus the two CRC bytes; payload is whatever lies above the last two.
    always_comb begin
        take = (rem < 17'(LANE_COUNT)) ? rem : 17'(LANE_COUNT);
        pay  = '0;
        if (rem > 17'd2)
            pay = ((rem - 17'd2) < take) ? (rem - 17'd2) : take;
        be = '0;
        for (int i = 0; i < LANE_COUNT; i++)
            be[i] = 17'(i) < pay;
        pl_ok = body_beat && pay != '0 && VC_EN[vc_o];
    end

    always_comb begin
        next_state   = state;
        next_hdr_buf = hdr_buf;
        next_hdr_cnt = hdr_cnt;
        next_rem     = rem;
        if (hdr_beat) begin
            next_hdr_buf = hdr_word;
            next_hdr_cnt = hdr_cnt_new;
            next_state   = HDR;
            if (decode) begin
                next_hdr_cnt = '0;
                if (is_short) begin
                    next_state = IDLE;
                end else begin
                    next_state = BODY;
                    next_rem   = {1'b0, hdr_word[23:8]} + 17'd2;
                end
            end
        end else if (body_beat) begin
            next_rem = rem - take;
            if (rem == take)
                next_state = IDLE;
        end
    end

    always_ff @(posedge clk_byte_fr_i) begin
        if (!reset_byte_fr_n_i) begin
            state   <= IDLE;
            hdr_buf <= '0;
            hdr_cnt <= '0;
            rem     <= '0;
        end else begin
            state   <= next_state;
            hdr_buf <= next_hdr_buf;
            hdr_cnt <= next_hdr_cnt;
            rem     <= next_rem;
        end
    end

    always_ff @(posedge clk_byte_fr_i) begin
        if (!reset_byte_fr_n_i) begin
            sp_en_o        <= 1'b0;
            lp_en_o        <= 1'b0;
            vc_o           <= '0;
            dt_o           <= '0;
            wc_o           <= '0;
            ecc_o          <= '0;
            pl_data_o      <= '0;
            pl_be_o        <= '0;
            pl_valid_o     <= 1'b0;
            frame_active_o <= '0;
            err_trunc_o    <= 1'b0;
            err_fe_o       <= 1'b0;
        end else begin
            sp_en_o     <= decode && is_short;
            lp_en_o     <= decode && !is_short;
            err_trunc_o <= start && state != IDLE;
            err_fe_o    <= 1'b0;
            pl_valid_o  <= pl_ok;
            pl_be_o     <= pl_ok ? be : '0;
            if (body_beat)
                pl_data_o <= data_i;
            if (decode) begin
                vc_o  <= hdr_word[7:6];
                dt_o  <= hdr_word[5:0];
                wc_o  <= hdr_word[23:8];
                ecc_o <= hdr_word[31:24];
            end
            // FS sets the VC's frame bit; FE clears it, or flags an error if no frame was open.
            if (decode && is_short) begin
                if (hdr_word[5:0] == 6'h00) begin
                    frame_active_o[hdr_word[7:6]] <= 1'b1;
                end else if (hdr_word[5:0] == 6'h01) begin
                    if (frame_active_o[hdr_word[7:6]])
                        frame_active_o[hdr_word[7:6]] <= 1'b0;
                    else
                        err_fe_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_csi2_vc_demux.sv
// Testbench for csi2_vc_demux: three instances (4, 2 and 1 lanes, the 1-lane one with VC1
// disabled) driven one at a time, checked beat by beat against a packet-level byte model.
module tb_csi2_vc_demux;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n;

    logic [ND-1:0][31:0] data;
    logic [ND-1:0]       valid, sot;

    wire  [ND-1:0]       sp, lp, plv, etr, efe;
    wire  [ND-1:0][1:0]  vc;
    wire  [ND-1:0][5:0]  dt;
    wire  [ND-1:0][15:0] wc;
    wire  [ND-1:0][7:0]  ecc;
    wire  [ND-1:0][31:0] pld;
    wire  [ND-1:0][3:0]  plbe, fa;

    // Reference model state, per instance
    logic [1:0]  mvc  [ND];
    logic [5:0]  mdt  [ND];
    logic [15:0] mwc  [ND];
    logic [7:0]  mecc [ND];
    logic [3:0]  mfa  [ND];
    bit          mid  [ND];

    int         checks, failures;
    int         plSeen;
    logic [3:0] lastBe;
    bit         spSeen, lpSeen, feSeen, trSeen;

    typedef struct {
        int         k;
        logic [7:0] di;
        logic [15:0] wcv;
        int         plBeats;
        logic [3:0] lastBe;
        logic [3:0] fa;
        bit         sp;
        bit         lp;
        bit         fe;
    } vec_t;

    vec_t vecs [13];

    // Free-running byte clock
    always #5 clk = ~clk;

    csi2_vc_demux #(.LANE_COUNT(4), .VC_EN(4'hF)) d4 (
        .clk_byte_fr_i(clk), .reset_byte_fr_n_i(rst_n),
        .data_i(data[0]), .valid_i(valid[0]), .sot_i(sot[0]),
        .sp_en_o(sp[0]), .lp_en_o(lp[0]), .vc_o(vc[0]), .dt_o(dt[0]), .wc_o(wc[0]), .ecc_o(ecc[0]),
        .pl_data_o(pld[0]), .pl_be_o(plbe[0]), .pl_valid_o(plv[0]),
        .frame_active_o(fa[0]), .err_trunc_o(etr[0]), .err_fe_o(efe[0]));

    csi2_vc_demux #(.LANE_COUNT(2), .VC_EN(4'hF)) d2 (
        .clk_byte_fr_i(clk), .reset_byte_fr_n_i(rst_n),
        .data_i(data[1][15:0]), .valid_i(valid[1]), .sot_i(sot[1]),
        .sp_en_o(sp[1]), .lp_en_o(lp[1]), .vc_o(vc[1]), .dt_o(dt[1]), .wc_o(wc[1]), .ecc_o(ecc[1]),
        .pl_data_o(pld[1][15:0]), .pl_be_o(plbe[1][1:0]), .pl_valid_o(plv[1]),
        .frame_active_o(fa[1]), .err_trunc_o(etr[1]), .err_fe_o(efe[1]));

    csi2_vc_demux #(.LANE_COUNT(1), .VC_EN(4'b1101)) d1 (
        .clk_byte_fr_i(clk), .reset_byte_fr_n_i(rst_n),
        .data_i(data[2][7:0]), .valid_i(valid[2]), .sot_i(sot[2]),
        .sp_en_o(sp[2]), .lp_en_o(lp[2]), .vc_o(vc[2]), .dt_o(dt[2]), .wc_o(wc[2]), .ecc_o(ecc[2]),
        .pl_data_o(pld[2][7:0]), .pl_be_o(plbe[2][0:0]), .pl_valid_o(plv[2]),
        .frame_active_o(fa[2]), .err_trunc_o(etr[2]), .err_fe_o(efe[2]));

    assign pld[1][31:16] = '0;
    assign plbe[1][3:2]  = '0;
    assign pld[2][31:8]  = '0;
    assign plbe[2][3:1]  = '0;

    function automatic int lanesOf(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction

    function automatic logic [3:0] vcEnOf(input int k);
        return (k == 2) ? 4'b1101 : 4'hF;
    endfunction

    // Drive one beat into instance k (others idle), then sample just after the edge
    task automatic applyStimulus(input int k, input logic [31:0] d, input logic v, input logic s);
        @(negedge clk);
        valid   = '0;
        sot     = '0;
        data[k] = d;
        valid[k] = v;
        sot[k]   = s;
        @(posedge clk);
        #1;
        valid = '0;
        sot   = '0;
    endtask

    task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s idx%0d actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    task automatic checkBeat(input int k, input bit eSp, input bit eLp, input bit ePv,
                             input logic [3:0] eBe, input logic [31:0] eData, input bit eTr, input bit eFe);
        logic [31:0] mask;
        checkOutput("sp_en", k, sp[k], eSp);
        checkOutput("lp_en", k, lp[k], eLp);
        checkOutput("pl_valid", k, plv[k], ePv);
        if (ePv) begin
            mask = '0;
            for (int i = 0; i < 4; i++)
                if (eBe[i]) mask[8*i +: 8] = 8'hFF;
            checkOutput("pl_be", k, plbe[k], eBe);
            checkOutput("pl_data", k, pld[k] & mask, eData & mask);
        end
        checkOutput("err_trunc", k, etr[k], eTr);
        checkOutput("err_fe", k, efe[k], eFe);
        checkOutput("vc", k, vc[k], mvc[k]);
        checkOutput("dt", k, dt[k], mdt[k]);
        checkOutput("wc", k, wc[k], mwc[k]);
        checkOutput("ecc", k, ecc[k], mecc[k]);
        checkOutput("frame_active", k, fa[k], mfa[k]);
        if (plv[k] === 1'b1) begin
            plSeen++;
            lastBe = plbe[k];
        end
        if (sp[k] === 1'b1)  spSeen = 1'b1;
        if (lp[k] === 1'b1)  lpSeen = 1'b1;
        if (efe[k] === 1'b1) feSeen = 1'b1;
        if (etr[k] === 1'b1) trSeen = 1'b1;
    endtask

    // Random idle beats; sot and data are garbage and must be ignored
    task automatic gapBeats(input int k, input int pct);
        while ($urandom_range(0, 99) < pct) begin
            applyStimulus(k, $urandom, 1'b0, 1'($urandom));
            checkBeat(k, 0, 0, 0, '0, '0, 0, 0);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        valid = '0;
        sot   = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            mvc[k] = '0; mdt[k] = '0; mwc[k] = '0; mecc[k] = '0; mfa[k] = '0; mid[k] = 1'b0;
        end
        for (int k = 0; k < ND; k++) begin
            checkBeat(k, 0, 0, 0, '0, '0, 0, 0);
            checkOutput("rst_pl_data", k, pld[k], 32'h0);
            checkOutput("rst_pl_be", k, plbe[k], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Send one packet as a byte stream split into lane-wide beats. stopAt >= 0 abandons the
    // packet before that body beat, so the next sot on this instance is a truncation.
    task automatic sendPacket(input int k, input logic [7:0] di, input logic [15:0] wcv,
                              input int pct, input int stopAt);
        int          L, nHdr, nBody, cnt;
        logic [7:0]  hb [4];
        logic [31:0] d;
        logic [3:0]  en, be;
        bit          isShort, eTr, eFe, ePv;
        L       = lanesOf(k);
        en      = vcEnOf(k);
        nHdr    = 4 / L;
        hb[0]   = di;
        hb[1]   = wcv[7:0];
        hb[2]   = wcv[15:8];
        hb[3]   = 8'($urandom);
        isShort = di[5:0] <= 6'h0F;
        for (int b = 0; b < nHdr; b++) begin
            gapBeats(k, pct);
            d = '0;
            for (int i = 0; i < L; i++)
                d[8*i +: 8] = hb[b*L + i];
            applyStimulus(k, d, 1'b1, b == 0);
            eTr    = (b == 0) && mid[k];
            mid[k] = 1'b1;
            eFe    = 1'b0;
            if (b == nHdr - 1) begin
                mvc[k] = di[7:6]; mdt[k] = di[5:0]; mwc[k] = wcv; mecc[k] = hb[3];
                if (isShort && di[5:0] == 6'h00) begin
                    mfa[k][di[7:6]] = 1'b1;
                end else if (isShort && di[5:0] == 6'h01) begin
                    if (mfa[k][di[7:6]]) mfa[k][di[7:6]] = 1'b0;
                    else eFe = 1'b1;
                end
                if (isShort) mid[k] = 1'b0;
                checkBeat(k, isShort, !isShort, 0, '0, '0, eTr, eFe);
            end else begin
                checkBeat(k, 0, 0, 0, '0, '0, eTr, 0);
            end
        end
        if (isShort) return;
        nBody = (int'(wcv) + 2 + L - 1) / L;
        for (int b = 0; b < nBody; b++) begin
            if (b == stopAt) return;
            gapBeats(k, pct);
            d = $urandom;
            applyStimulus(k, d, 1'b1, 1'b0);
            cnt = 0;
            for (int i = 0; i < L; i++)
                if (b*L + i < int'(wcv)) cnt++;
            be  = 4'((1 << cnt) - 1);
            ePv = (cnt > 0) && en[mvc[k]];
            checkBeat(k, 0, 0, ePv, be, d, 0, 0);
        end
        mid[k] = 1'b0;
    endtask

    initial begin
        int         k, sel, dtv, stop;
        logic [7:0] di;
        logic [15:0] w;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        valid    = '0;
        sot      = '0;
        data     = '0;
        resetDut();

        //          k  DI     WC        plBeats lastBe fa       sp lp fe
        vecs[0]  = '{0, 8'h40, 16'h0001, 0,  4'h0, 4'b0010, 1, 0, 0};
        vecs[1]  = '{0, 8'h2A, 16'd10,   3,  4'h3, 4'b0010, 0, 1, 0};
        vecs[2]  = '{2, 8'h2A, 16'd10,   10, 4'h1, 4'b0000, 0, 1, 0};
        vecs[3]  = '{2, 8'h6A, 16'd8,    0,  4'h0, 4'b0000, 0, 1, 0};
        vecs[4]  = '{2, 8'h2A, 16'd8,    8,  4'h1, 4'b0000, 0, 1, 0};
        vecs[5]  = '{1, 8'h2B, 16'd0,    0,  4'h0, 4'b0000, 0, 1, 0};
        vecs[6]  = '{1, 8'h01, 16'd0,    0,  4'h0, 4'b0000, 1, 0, 1};
        vecs[7]  = '{1, 8'h00, 16'd0,    0,  4'h0, 4'b0001, 1, 0, 0};
        vecs[8]  = '{1, 8'hC0, 16'd0,    0,  4'h0, 4'b1001, 1, 0, 0};
        vecs[9]  = '{1, 8'h00, 16'd0,    0,  4'h0, 4'b1001, 1, 0, 0};
        vecs[10] = '{1, 8'h01, 16'd0,    0,  4'h0, 4'b1000, 1, 0, 0};
        vecs[11] = '{1, 8'h2A, 16'd5,    3,  4'h1, 4'b1000, 0, 1, 0};
        vecs[12] = '{0, 8'h2A, 16'd3,    1,  4'h7, 4'b0010, 0, 1, 0};

        for (int i = 0; i < 13; i++) begin
            plSeen = 0; lastBe = '0; spSeen = 0; lpSeen = 0; feSeen = 0;
            sendPacket(vecs[i].k, vecs[i].di, vecs[i].wcv, 0, -1);
            checkOutput("vec_pl_beats", i, plSeen, vecs[i].plBeats);
            if (vecs[i].plBeats > 0)
                checkOutput("vec_last_be", i, lastBe, vecs[i].lastBe);
            checkOutput("vec_sp", i, spSeen, vecs[i].sp);
            checkOutput("vec_lp", i, lpSeen, vecs[i].lp);
            checkOutput("vec_fe", i, feSeen, vecs[i].fe);
            checkOutput("vec_fa", i, fa[vecs[i].k], vecs[i].fa);
        end

        // sot on the third body beat of a 2-lane WC=16 packet
        trSeen = 0;
        sendPacket(1, 8'h2A, 16'd16, 0, 2);
        sendPacket(1, 8'h48, 16'hBEEF, 0, -1);
        checkOutput("trunc_seen", 1, trSeen, 1);
        checkOutput("trunc_new_wc", 1, wc[1], 16'hBEEF);
        checkOutput("trunc_new_vc", 1, vc[1], 2'd1);

        // Reset mid-packet: FSM back to IDLE, frame bits cleared, stray body beat ignored
        sendPacket(1, 8'h00, 16'd0, 0, -1);
        sendPacket(1, 8'h2A, 16'd12, 0, 1);
        resetDut();
        applyStimulus(1, 32'h1234_5678, 1'b1, 1'b0);
        checkBeat(1, 0, 0, 0, '0, '0, 0, 0);
        feSeen = 0;
        sendPacket(1, 8'h01, 16'd0, 0, -1);
        checkOutput("post_reset_fe", 1, feSeen, 1);

        // Randomized packets across all instances, with idle gaps and abandoned packets
        for (int n = 0; n < 200; n++) begin
            k   = int'($urandom_range(0, 2));
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      dtv = 0;
            else if (sel == 1) dtv = 1;
            else if (sel == 2) dtv = int'($urandom_range(2, 15));
            else               dtv = int'($urandom_range(16, 63));
            di = {2'($urandom), 6'(dtv)};
            if (dtv <= 15) w = 16'($urandom);
            else           w = 16'($urandom_range(0, 20));
            stop = -1;
            if ($urandom_range(0, 7) == 0) stop = int'($urandom_range(0, 3));
            sendPacket(k, di, w, 25, stop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
